prog_loader: RTL and testbench

//  Byte-stream program loader: master-side writer for the CPU's instruction/data memories.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/loader_byte_packer.sv | 37 +++
 rtl/prog_loader.sv | 175 +++++++++++++++++
 tb/tb_prog_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants and FSM state encoding for the byte-stream program loader.
// Optional checksum trailer is selected by the LOADER_CHKSUM_EN macro.
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEL_W  = 2;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  localparam logic [SEL_W-1:0] TGT_INSTR = 2'd0;
  localparam logic [SEL_W-1:0] TGT_CONST = 2'd1;
  localparam logic [SEL_W-1:0] TGT_VAR   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TARGET = 3'd1,
    ST_COUNT  = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHECK  = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; the 4th byte completes
// the word combinationally so the write can be registered on that same edge.
module loader_byte_packer
  import loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] data,
  output logic              word_ready_c,
  output logic [WORD_W-1:0] word_c
);

  localparam int unsigned HOLD_W = WORD_W - BYTE_W;

  logic [1:0]        byte_cnt;
  logic [HOLD_W-1:0] shreg;

  // Older bytes shift toward bit 0 so the first byte ends up in [7:0]
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      byte_cnt <= 2'd0;
      shreg    <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      shreg    <= '0;
    end else if (push) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= {data, shreg[HOLD_W-1:BYTE_W]};
    end
  end

  assign word_ready_c = push && (byte_cnt == 2'd3);
  assign word_c       = {data, shreg};

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses SYNC/TARGET/COUNT/data[/CHK] frames and writes words
// into the CPU memories while holding the core. CHK trailer enabled by LOADER_CHKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [BYTE_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              MEM_WE,
  output logic [SEL_W-1:0]  MEM_SEL,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [WORD_W-1:0] MEM_WDATA,
  output logic              CPU_HOLD,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  state_t            state;
  logic [CNT_W-1:0]  words_left;
  logic [TO_W-1:0]   idle_cnt;
`ifdef LOADER_CHKSUM_EN
  logic [BYTE_W-1:0] chk;
`endif

  logic              xfer;
  logic              sync_seen;
  logic              tmr_active;
  logic              timeout_hit;
  logic              pk_clear;
  logic              pk_push;
  logic              word_ready_c;
  logic [WORD_W-1:0] word_c;

  assign xfer        = RX_VALID && RX_READY;
  assign sync_seen   = xfer && (RX_DATA == SYNC_BYTE);
  assign tmr_active  = (state != ST_IDLE) && (state != ST_ERR);
  assign timeout_hit = tmr_active && !xfer && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign pk_clear    = (state == ST_ERR) || ((state == ST_IDLE) && sync_seen);
  assign pk_push     = xfer && (state == ST_DATA);

  loader_byte_packer u_packer (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .clear        (pk_clear),
    .push         (pk_push),
    .data         (RX_DATA),
    .word_ready_c (word_ready_c),
    .word_c       (word_c)
  );

  // Inter-byte watchdog, counting only while a frame is in progress
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      idle_cnt <= '0;
    end else if (tmr_active && !xfer) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

  // Frame FSM with registered outputs
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= ST_IDLE;
      RX_READY   <= 1'b1;
      MEM_WE     <= 1'b0;
      MEM_SEL    <= TGT_INSTR;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      CPU_HOLD   <= 1'b0;
      LOAD_DONE  <= 1'b0;
      LOAD_ERR   <= 1'b0;
      words_left <= '0;
`ifdef LOADER_CHKSUM_EN
      chk        <= '0;
`endif
    end else begin
      MEM_WE    <= 1'b0;
      LOAD_DONE <= 1'b0;
      RX_READY  <= 1'b1;
      if (timeout_hit) begin
        state    <= ST_ERR;
        LOAD_ERR <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE, ST_ERR: begin
            // Any sync byte (re)starts a frame; everything else is discarded
            if (sync_seen) begin
              state    <= ST_TARGET;
              CPU_HOLD <= 1'b1;
              LOAD_ERR <= 1'b0;
              MEM_ADDR <= '0;
`ifdef LOADER_CHKSUM_EN
              chk      <= '0;
`endif
            end
          end
          ST_TARGET: begin
            if (xfer) begin
              if (RX_DATA > BYTE_W'(TGT_VAR)) begin
                state    <= ST_ERR;
                LOAD_ERR <= 1'b1;
              end else begin
                MEM_SEL <= RX_DATA[SEL_W-1:0];
                state   <= ST_COUNT;
              end
            end
          end
          ST_COUNT: begin
            if (xfer) begin
              words_left <= (RX_DATA == '0) ? CNT_W'(DEPTH) : CNT_W'(RX_DATA);
              state      <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (xfer) begin
`ifdef LOADER_CHKSUM_EN
              chk <= chk ^ RX_DATA;
`endif
              if (word_ready_c) begin
                MEM_WE    <= 1'b1;
                MEM_WDATA <= word_c;
                RX_READY  <= 1'b0;
                state     <= ST_WRITE;
              end
            end
          end
          ST_WRITE: begin
            MEM_ADDR   <= MEM_ADDR + ADDR_W'(1);
            words_left <= words_left - CNT_W'(1);
            if (words_left == CNT_W'(1)) begin
`ifdef LOADER_CHKSUM_EN
              state <= ST_CHECK;
`else
              state     <= ST_IDLE;
              LOAD_DONE <= 1'b1;
              CPU_HOLD  <= 1'b0;
`endif
            end else begin
              state <= ST_DATA;
            end
          end
`ifdef LOADER_CHKSUM_EN
          ST_CHECK: begin
            if (xfer) begin
              if (RX_DATA == chk) begin
                state     <= ST_IDLE;
                LOAD_DONE <= 1'b1;
                CPU_HOLD  <= 1'b0;
              end else begin
                state    <= ST_ERR;
                LOAD_ERR <= 1'b1;
              end
            end
          end
`endif
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized directed bench for prog_loader with a frame-level expected-write model.
// Follows the LOADER_CHKSUM_EN macro of the build for the CHK trailer.
module tb_prog_loader;

  localparam int unsigned TO = 200;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic        MEM_WE;
  logic [1:0]  MEM_SEL;
  logic [6:0]  MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        CPU_HOLD;
  logic        LOAD_DONE;
  logic        LOAD_ERR;

  prog_loader #(.ADDR_W(7), .TIMEOUT_CYC(TO)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .MEM_WE    (MEM_WE),
    .MEM_SEL   (MEM_SEL),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .CPU_HOLD  (CPU_HOLD),
    .LOAD_DONE (LOAD_DONE),
    .LOAD_ERR  (LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  logic [40:0] wq[$];
  logic [7:0]  payload[$];
  int          done_cnt = 0;
  int          hold_we_bad = 0;
  int          rdy_we_bad = 0;
  int          hold_done_bad = 0;
  logic        prev_hold = 1'b0;

  // Observe memory writes and frame completion away from the active edge
  always @(negedge CLK) begin
    if (MEM_WE) begin
      wq.push_back({MEM_SEL, MEM_ADDR, MEM_WDATA});
      if (!CPU_HOLD) hold_we_bad++;
      if (RX_READY) rdy_we_bad++;
    end
    if (LOAD_DONE) begin
      done_cnt++;
      if (CPU_HOLD || !prev_hold) hold_done_bad++;
    end
    prev_hold = CPU_HOLD;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    RX_VALID = 1'b1;
    RX_DATA  = b;
    while (!RX_READY && guard < 8) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 8) check("rx_ready_wait", 32'(RX_READY), 32'd1);
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  task automatic clear_mon();
    wq.delete();
    done_cnt      = 0;
    hold_we_bad   = 0;
    rdy_we_bad    = 0;
    hold_done_bad = 0;
  endtask

  // Sends one frame built from payload and compares against the expected writes
  task automatic run_frame(input string tag, input logic [1:0] sel, input logic [7:0] cnt,
                           input bit bad_chk, input int gap_max);
    int          nw;
    int          got;
    logic [7:0]  chk;
    logic [40:0] e;
    logic [31:0] w;
    bit          exp_err;
    nw = (cnt == 8'd0) ? 128 : int'(cnt);
    clear_mon();
    send_byte(8'hA5);
    check({tag, "/hold_after_sync"}, 32'(CPU_HOLD), 32'd1);
    send_byte({6'd0, sel});
    send_byte(cnt);
    chk = 8'h00;
    foreach (payload[i]) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge CLK);
      send_byte(payload[i]);
      chk ^= payload[i];
    end
    exp_err = 1'b0;
`ifdef LOADER_CHKSUM_EN
    send_byte(bad_chk ? ~chk : chk);
    exp_err = bad_chk;
`endif
    repeat (4) @(negedge CLK);
    check({tag, "/n_writes"}, 32'(wq.size()), 32'(nw));
    got = (wq.size() < nw) ? wq.size() : nw;
    for (int i = 0; i < got; i++) begin
      e = wq[i];
      w = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
      check($sformatf("%s/sel%0d", tag, i), 32'(e[40:39]), 32'(sel));
      check($sformatf("%s/addr%0d", tag, i), 32'(e[38:32]), 32'(i % 128));
      check($sformatf("%s/data%0d", tag, i), e[31:0], w);
    end
    check({tag, "/done_pulses"}, 32'(done_cnt), exp_err ? 32'd0 : 32'd1);
    check({tag, "/load_err"}, 32'(LOAD_ERR), 32'(exp_err));
    check({tag, "/cpu_hold_end"}, 32'(CPU_HOLD), 32'(exp_err));
    check({tag, "/hold_during_we"}, 32'(hold_we_bad), 32'd0);
    check({tag, "/ready_during_we"}, 32'(rdy_we_bad), 32'd0);
    check({tag, "/hold_at_done"}, 32'(hold_done_bad), 32'd0);
  endtask

  initial begin
    int k;
    // Reset state
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    check("rst/rx_ready", 32'(RX_READY), 32'd1);
    check("rst/cpu_hold", 32'(CPU_HOLD), 32'd0);
    check("rst/mem_we", 32'(MEM_WE), 32'd0);
    check("rst/load_err", 32'(LOAD_ERR), 32'd0);
    check("rst/load_done", 32'(LOAD_DONE), 32'd0);
    check("rst/mem_addr", 32'(MEM_ADDR), 32'd0);

    // Two-word INSTR frame
    payload = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame("t2", 2'd0, 8'd2, 1'b0, 0);

    // Illegal target, then recovery to DATA_VAR
    clear_mon();
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (2) @(negedge CLK);
    check("t3/load_err", 32'(LOAD_ERR), 32'd1);
    check("t3/cpu_hold", 32'(CPU_HOLD), 32'd1);
    check("t3/no_write", 32'(wq.size()), 32'd0);
    send_byte(8'h77);
    check("t3/err_drop", 32'(LOAD_ERR), 32'd1);
    payload = '{8'h01, 8'h00, 8'h00, 8'h00};
    run_frame("t3b", 2'd2, 8'd1, 1'b0, 0);

`ifdef LOADER_CHKSUM_EN
    // Bad checksum: word still written, error instead of done
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("t4", 2'd1, 8'd1, 1'b1, 0);
`endif

    // Randomized short frames with idle gaps between bytes
    for (k = 0; k < 6; k++) begin
      logic [1:0] s;
      logic [7:0] c;
      s = 2'($urandom_range(2, 0));
      c = 8'($urandom_range(8, 1));
      payload.delete();
      for (int j = 0; j < 4 * int'(c); j++) payload.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", k), s, c, 1'b0, 2);
    end

    // Full 128-word frame; nothing written past it
    payload.delete();
    for (int j = 0; j < 512; j++) payload.push_back(8'($urandom));
    run_frame("t5", 2'd1, 8'd0, 1'b0, 0);
    send_byte(8'h3C);
    repeat (3) @(negedge CLK);
    check("t5/no_129th", 32'(wq.size()), 32'd128);

    // Stall mid-word until the watchdog fires
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hC3);
    send_byte(8'h3C);
    repeat (TO - 2) @(negedge CLK);
    check("t6/no_early_err", 32'(LOAD_ERR), 32'd0);
    k = 0;
    while (!LOAD_ERR && k < 10) begin
      @(negedge CLK);
      k++;
    end
    check("t6/timeout_err", 32'(LOAD_ERR), 32'd1);
    check("t6/cpu_hold", 32'(CPU_HOLD), 32'd1);
    check("t6/no_write", 32'(wq.size()), 32'd0);
    check("t6/rx_ready", 32'(RX_READY), 32'd1);

    // Asynchronous reset in the middle of a word
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h99);
    send_byte(8'h88);
    RESETn = 1'b0;
    #1;
    check("rstmid/rx_ready", 32'(RX_READY), 32'd1);
    check("rstmid/cpu_hold", 32'(CPU_HOLD), 32'd0);
    check("rstmid/mem_we", 32'(MEM_WE), 32'd0);
    check("rstmid/load_err", 32'(LOAD_ERR), 32'd0);
    check("rstmid/load_done", 32'(LOAD_DONE), 32'd0);
    check("rstmid/mem_addr", 32'(MEM_ADDR), 32'd0);
    check("rstmid/mem_sel", 32'(MEM_SEL), 32'd0);
    check("rstmid/mem_wdata", MEM_WDATA, 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    payload.delete();
    for (int j = 0; j < 4; j++) payload.push_back(8'($urandom));
    run_frame("post_rst", 2'd0, 8'd1, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
